sdram_burst_reader: RTL and testbench

Avalon-MM burst read master that sits directly upstream of the SDRAM slave on `sdram_intf`. It accepts a linear read command (byte address, beat count) from the NPU load engine and splits it into bursts of at most `MAX_BURST` beats. It buffers the returned beats in a local FIFO and presents them as a valid/ready stream with a last flag. It never writes.

---
 rtl/sdram_burst_reader_pkg.sv | 19 +
 rtl/sdram_burst_reader_if.sv | 24 ++
 rtl/sdram_burst_reader_fifo.sv | 52 +++++
 rtl/sdram_burst_reader.sv | 152 +++++++++++++++
 tb/tb_sdram_burst_reader.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_burst_reader_pkg.sv
// Shared constants, widths and FSM encoding for the SDRAM burst read path.
package sdram_pkg;
    localparam int SDRAM_ADDR_W  = 32;
    localparam int SDRAM_BURST_W = 11;
    localparam int SDRAM_W_DFLT  = 128;
    localparam int BEAT_BYTES    = SDRAM_W_DFLT / 8;

    function automatic int beat_bytes(input int data_w);
        return data_w / 8;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITSPACE,
        S_REQ,
        S_DATA,
        S_FIN
    } sdram_rd_state_e;
endpackage

// File: rtl/sdram_burst_reader_if.sv
// Avalon-MM bus between a burst master and the SDRAM slave.
interface sdram_intf #(
    parameter int DATA_W = sdram_pkg::SDRAM_W_DFLT
);
    logic [sdram_pkg::SDRAM_ADDR_W-1:0]  address;
    logic [sdram_pkg::SDRAM_BURST_W-1:0] burstcount;
    logic                                read;
    logic                                write;
    logic [DATA_W-1:0]                   writedata;
    logic [sdram_pkg::beat_bytes(DATA_W)-1:0] byteenable;
    logic                                waitrequest;
    logic [DATA_W-1:0]                   readdata;
    logic                                readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_burst_reader_fifo.sv
// Show-ahead synchronous FIFO holding returned beats; reports free entries for burst admission.
module sdram_rd_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != DEPTH_C) || w_pop);

    // NOTE: storage is not reset; emptiness is tracked by the count, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_free  = DEPTH_C - r_count;
endmodule

// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read master: splits a linear read into bounded bursts and
// streams the returned beats out through a local FIFO with a last flag.
module sdram_burst_reader
    import sdram_pkg::*;
#(
    parameter int SDRAM_W    = SDRAM_W_DFLT,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_addr,
    input  logic [15:0]        cmd_beats,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SDRAM_W-1:0] out_data,
    output logic               out_last,
    output logic               done,
    sdram_intf.master          sdram
);
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SDRAM_ADDR_W-1:0]  BEAT_BYTES_L = SDRAM_ADDR_W'(beat_bytes(SDRAM_W));
    localparam logic [SDRAM_ADDR_W-1:0]  ADDR_MASK    = ~(BEAT_BYTES_L - 1'b1);
    localparam logic [SDRAM_BURST_W-1:0] MAX_LEN      = SDRAM_BURST_W'(MAX_BURST);

    sdram_rd_state_e            r_state, w_state_nxt;
    logic [SDRAM_ADDR_W-1:0]    r_addr, w_addr_nxt;
    logic [15:0]                r_remaining, w_remaining_nxt;
    logic [SDRAM_BURST_W-1:0]   r_len, w_len_nxt;
    logic [SDRAM_BURST_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
    logic                       r_read, w_read_nxt;
    logic [SDRAM_ADDR_W-1:0]    r_address, w_address_nxt;
    logic [SDRAM_BURST_W-1:0]   r_burstcount, w_burstcount_nxt;
    logic                       r_done, w_done_nxt;

    logic [SDRAM_BURST_W-1:0]   w_len;
    logic                       w_push;
    logic                       w_push_last;
    logic                       w_burst_end;
    logic                       w_pop;
    logic                       w_fifo_empty;
    logic [FREE_W-1:0]          w_free;
    logic [SDRAM_W:0]           w_head;

    assign w_len       = (r_remaining >= 16'(MAX_BURST)) ? MAX_LEN : r_remaining[SDRAM_BURST_W-1:0];
    assign w_push      = (r_state == S_DATA) && sdram.readdatavalid;
    assign w_burst_end = (r_beat_cnt == r_len - 1'b1);
    // Final beat of the whole command: last beat of the burst that exhausts the remaining count.
    assign w_push_last = (r_remaining == 16'(r_len)) && w_burst_end;
    assign w_pop       = out_valid && out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_remaining_nxt  = r_remaining;
        w_len_nxt        = r_len;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_read_nxt       = r_read;
        w_address_nxt    = r_address;
        w_burstcount_nxt = r_burstcount;
        w_done_nxt       = 1'b0;
        unique case (r_state)
            S_IDLE: if (cmd_valid) begin
                w_addr_nxt      = cmd_addr & ADDR_MASK;
                w_remaining_nxt = cmd_beats;
                w_state_nxt     = (cmd_beats == '0) ? S_FIN : S_WAITSPACE;
            end
            // readdatavalid cannot be stalled, so the whole burst must fit before it is requested.
            S_WAITSPACE: if (32'(w_free) >= 32'(w_len)) begin
                w_len_nxt        = w_len;
                w_read_nxt       = 1'b1;
                w_address_nxt    = r_addr;
                w_burstcount_nxt = w_len;
                w_state_nxt      = S_REQ;
            end
            S_REQ: if (!sdram.waitrequest) begin
                w_read_nxt     = 1'b0;
                w_beat_cnt_nxt = '0;
                w_state_nxt    = S_DATA;
            end
            S_DATA: if (sdram.readdatavalid) begin
                w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                if (w_burst_end) begin
                    w_addr_nxt      = r_addr + 32'(r_len) * BEAT_BYTES_L;
                    w_remaining_nxt = r_remaining - 16'(r_len);
                    w_state_nxt     = w_push_last ? S_FIN : S_WAITSPACE;
                end
            end
            // Complete on the cycle the FIFO becomes empty so done follows the last pop by one cycle.
            S_FIN: if (w_fifo_empty || ((w_free == FREE_W'(FIFO_DEPTH - 1)) && w_pop)) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state updates use non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_len        <= '0;
            r_beat_cnt   <= '0;
            r_read       <= 1'b0;
            r_address    <= '0;
            r_burstcount <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_remaining  <= w_remaining_nxt;
            r_len        <= w_len_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_read       <= w_read_nxt;
            r_address    <= w_address_nxt;
            r_burstcount <= w_burstcount_nxt;
            r_done       <= w_done_nxt;
        end
    end

    sdram_rd_fifo #(
        .WIDTH (SDRAM_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({w_push_last, sdram.readdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_fifo_empty),
        .o_free  (w_free)
    );

    assign cmd_ready = (r_state == S_IDLE);
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_head[SDRAM_W-1:0];
    assign out_last  = out_valid && w_head[SDRAM_W];
    assign done      = r_done;

    assign sdram.read       = r_read;
    assign sdram.address    = r_address;
    assign sdram.burstcount = r_burstcount;
    assign sdram.write      = 1'b0;
    assign sdram.writedata  = '0;
    assign sdram.byteenable = '1;
endmodule

// File: tb/tb_sdram_burst_reader.sv
// Scoreboard bench for sdram_burst_reader: Avalon slave model, random backpressure, reference queues.
module tb_sdram_burst_reader;
    import sdram_pkg::*;

    localparam int W  = 128;
    localparam int MB = 8;
    localparam int FD = 16;

    typedef struct { logic [W-1:0] data; logic last; } beat_t;
    typedef struct { logic [31:0] addr; int len; } burst_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  cmd_addr = '0;
    logic [15:0]  cmd_beats = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         done;

    sdram_intf #(.DATA_W(W)) bus ();

    sdram_burst_reader #(.SDRAM_W(W), .MAX_BURST(MB), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_beats (cmd_beats),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .sdram     (bus)
    );

    always #5 clk = ~clk;

    beat_t   exp_q[$];
    burst_t  burst_q[$];
    int      n_checks = 0;
    int      n_fail = 0;
    longint  cyc = 0;
    longint  exp_done_cyc = -10;
    int      done_cnt = 0;
    int      acc_cnt = 0;
    int      read_seen = 0;
    int      ready_mode = 0;
    int      wait_mode = 0;
    int      hold_cnt = 0;
    int      sl_left = 0;
    int      sl_idx = 0;
    int      sl_delay = 0;
    logic [31:0] sl_addr = '0;
    bit          prev_stall = 0;
    logic [31:0] prev_addr;
    logic [10:0] prev_bc;
    bit          prev_hold = 0;
    logic [W-1:0] prev_data;
    logic        prev_last;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [W-1:0] beat_data(input logic [31:0] a);
        logic [W-1:0] d;
        for (int i = 0; i < W/32; i++) d[32*i +: 32] = mem_word(a + 32'(4*i));
        return d;
    endfunction

    // Reference model: every beat of the command in order, and the burst split it implies.
    task automatic model_cmd(input logic [31:0] a, input int beats);
        logic [31:0] base;
        base = a & 32'hFFFF_FFF0;
        for (int k = 0; k < beats; k++)
            exp_q.push_back('{data: beat_data(base + 32'(16*k)), last: (k == beats - 1)});
        for (int off = 0; off < beats; off += MB)
            burst_q.push_back('{addr: base + 32'(16*off), len: ((beats - off) < MB) ? (beats - off) : MB});
    endtask

    task automatic send_cmd(input logic [31:0] a, input int beats);
        int t;
        t = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_beats = 16'(beats);
        forever begin
            @(negedge clk);
            if (cmd_ready || t > 1000) break;
            t++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        if (cmd_ready) begin
            model_cmd(a, beats);
            if (beats == 0) exp_done_cyc = cyc + 2;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int budget);
        int t;
        t = 0;
        while (done_cnt == prev && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", done_cnt != prev, 1'b1);
    endtask

    task automatic flush_model();
        exp_q.delete();
        burst_q.delete();
        exp_done_cyc = -10;
        prev_stall = 0;
        prev_hold = 0;
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (exp_q.size() == 0) begin
                check("no_stray_beat", out_valid, 1'b0);
            end else if (out_valid && out_ready) begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_last", out_last, e.last);
                if (e.last) exp_done_cyc = cyc + 1;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (done || cyc == exp_done_cyc) check("done_timing", done, cyc == exp_done_cyc);
            if (done) done_cnt++;
        end
    end

    // Avalon slave model: checks request stability/ordering and returns beats with random gaps.
    initial begin
        bus.waitrequest   = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("req_hold_read", bus.read, 1'b1);
                check("req_hold_addr", bus.address, prev_addr);
                check("req_hold_bc", bus.burstcount, prev_bc);
            end
            prev_stall = rst_n && bus.read && bus.waitrequest;
            prev_addr  = bus.address;
            prev_bc    = bus.burstcount;
            if (bus.read) begin
                read_seen++;
                check("single_outstanding", sl_left, 0);
            end
            if (rst_n && bus.read && !bus.waitrequest) begin
                acc_cnt++;
                if (burst_q.size() == 0) begin
                    check("stray_burst", bus.read, 1'b0);
                end else begin
                    burst_t b;
                    b = burst_q.pop_front();
                    check("burst_addr", bus.address, b.addr);
                    check("burst_len", bus.burstcount, 11'(b.len));
                end
                sl_left  = int'(bus.burstcount);
                sl_addr  = bus.address;
                sl_idx   = 0;
                sl_delay = $urandom_range(1, 3);
            end
            @(posedge clk); #1;
            case (wait_mode)
                0: bus.waitrequest = 1'b0;
                1: bus.waitrequest = ($urandom_range(0, 3) == 0);
                default: begin
                    if (hold_cnt > 0) begin
                        bus.waitrequest = 1'b1;
                        if (bus.read) hold_cnt--;
                    end else begin
                        bus.waitrequest = 1'b0;
                    end
                end
            endcase
            if (sl_left > 0 && sl_delay == 0 && $urandom_range(0, 4) != 0) begin
                bus.readdatavalid = 1'b1;
                bus.readdata      = beat_data(sl_addr + 32'(16*sl_idx));
                sl_idx++;
                sl_left--;
            end else begin
                if (sl_delay > 0) sl_delay--;
                bus.readdatavalid = 1'b0;
                bus.readdata      = {4{$urandom()}};
            end
        end
    end

    // Consumer backpressure.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 9) < 7);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int d;
        int a0;
        int r0;
        int t;
        logic [31:0] ra;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read", bus.read, 1'b0);
        check("rst_write", bus.write, 1'b0);
        check("rst_address", bus.address, 32'h0);
        check("rst_burstcount", bus.burstcount, 11'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("byteenable", bus.byteenable, 16'hFFFF);
        check("writedata", bus.writedata, 128'h0);
        rst_n = 1'b1;

        // Single short burst.
        d = done_cnt; a0 = acc_cnt;
        send_cmd(32'h2000_0000, 4);
        wait_done(d, 500);
        check("t1_bursts", acc_cnt - a0, 1);

        // Three bursts 8/8/4.
        d = done_cnt; a0 = acc_cnt;
        send_cmd(32'h2000_0000, 20);
        wait_done(d, 1000);
        check("t2_bursts", acc_cnt - a0, 3);

        // Consumer stalled: only the bursts that fit are requested.
        ready_mode = 2;
        d = done_cnt; a0 = acc_cnt;
        send_cmd(32'h3000_0108, 32);
        repeat (300) @(negedge clk);
        check("bp_bursts", acc_cnt - a0, 2);
        check("bp_no_read", bus.read, 1'b0);
        check("bp_fifo_full", out_valid, 1'b1);
        ready_mode = 1;
        wait_done(d, 3000);
        check("bp_total_bursts", acc_cnt - a0, 4);

        // Long waitrequest stall.
        ready_mode = 0;
        wait_mode  = 2;
        hold_cnt   = $urandom_range(50, 100);
        d = done_cnt; a0 = acc_cnt;
        send_cmd(32'h4000_0000, 8);
        wait_done(d, 1000);
        check("wr_bursts", acc_cnt - a0, 1);
        check("wr_hold_used", hold_cnt, 0);
        wait_mode = 0;

        // Zero-length command.
        d = done_cnt; r0 = read_seen;
        send_cmd(32'h5000_0000, 0);
        wait_done(d, 20);
        check("zero_no_read", read_seen - r0, 0);

        // Reset in the middle of the second burst's data phase.
        a0 = acc_cnt; t = 0;
        send_cmd(32'h2000_0000, 20);
        while ((acc_cnt - a0 < 2 || sl_idx < 2) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("mid_burst2_reached", (acc_cnt - a0 == 2) && (sl_idx >= 2), 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_read", bus.read, 1'b0);
        check("mr_address", bus.address, 32'h0);
        check("mr_burstcount", bus.burstcount, 11'h0);
        check("mr_out_valid", out_valid, 1'b0);
        check("mr_out_last", out_last, 1'b0);
        check("mr_done", done, 1'b0);
        check("mr_cmd_ready", cmd_ready, 1'b1);
        flush_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        while (sl_left > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        d = done_cnt;
        send_cmd(32'h6000_0040, 4);
        wait_done(d, 500);

        // Randomized commands, including address wrap.
        for (int i = 0; i < 15; i++) begin
            ra = (i % 5 == 4) ? 32'hFFFF_FF80 : $urandom();
            ready_mode = $urandom_range(0, 1);
            wait_mode  = $urandom_range(0, 1);
            d = done_cnt;
            send_cmd(ra, $urandom_range(0, 40));
            wait_done(d, 5000);
        end
        ready_mode = 0;
        wait_mode  = 0;
        repeat (10) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("burst_q_drained", burst_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
